// File: rtl/debug_trace_probe.sv
// debug_trace_probe: registered live view of one of NUM_CH probe channels,
// plus a circular trace buffer that records a selected channel on each
// sample_en. Recording stops after a masked value-match trigger and a
// POST_LEN-sample post-trigger window. Readout is oldest-relative.
module debug_trace_probe #(
    parameter int NUM_CH   = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 16,
    parameter int PTR_W    = 4,
    parameter int POST_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [ADDR_W-1:0]        check_addr,
    output logic [DATA_W-1:0]        check_data,
    input  logic                     sample_en,
    input  logic [ADDR_W-1:0]        cap_addr,
    input  logic [ADDR_W-1:0]        trig_addr,
    input  logic [DATA_W-1:0]        trig_value,
    input  logic [DATA_W-1:0]        trig_mask,
    input  logic                     arm,
    input  logic                     abort,
    output logic [1:0]               state,
    output logic [PTR_W:0]           count,
    output logic [PTR_W-1:0]         trig_pos,
    input  logic [PTR_W-1:0]         rd_idx,
    output logic [DATA_W-1:0]        rd_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_POST  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [PTR_W:0]   DEPTH_C    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX_C = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] POST_LEN_C = PTR_W'(POST_LEN);

    // Channel mux: out-of-range addresses read as zero.
    function automatic logic [DATA_W-1:0] ch_sel(
        input logic [ADDR_W-1:0]        addr,
        input logic [NUM_CH*DATA_W-1:0] data
    );
        logic [DATA_W-1:0] res;
        res = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr == ADDR_W'(i)) begin
                res = data[i*DATA_W +: DATA_W];
            end
        end
        return res;
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [PTR_W-1:0]    wptr_r;
    logic [PTR_W:0]      count_r;
    logic [PTR_W-1:0]    trig_pos_r;
    logic [PTR_W-1:0]    post_cnt_r;
    logic [DATA_W-1:0]   check_data_r;
    logic [DATA_W-1:0]   rd_data_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    logic [DATA_W-1:0]   cap_data_s;
    logic [DATA_W-1:0]   trig_data_s;
    logic                hit_s;
    logic                write_s;
    logic                clear_s;
    logic                abort_s;
    logic                trig_latch_s;
    logic [PTR_W-1:0]    oldest_s;
    logic [PTR_W-1:0]    rd_addr_s;
    logic                rd_valid_s;

    assign cap_data_s  = ch_sel(cap_addr, ch_data);
    assign trig_data_s = ch_sel(trig_addr, ch_data);
    assign hit_s       = (((trig_data_s ^ trig_value) & trig_mask) == {DATA_W{1'b0}});
    assign oldest_s    = (count_r < DEPTH_C) ? {PTR_W{1'b0}} : wptr_r;
    assign rd_addr_s   = oldest_s + rd_idx;
    assign rd_valid_s  = ({1'b0, rd_idx} < count_r);

    // Next-state and control strobes; abort has priority over arm and sampling.
    always_comb begin
        state_nxt_s  = state_r;
        write_s      = 1'b0;
        clear_s      = 1'b0;
        abort_s      = 1'b0;
        trig_latch_s = 1'b0;
        if (abort) begin
            state_nxt_s = ST_IDLE;
            abort_s     = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arm) begin
                        state_nxt_s = ST_ARMED;
                        clear_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (sample_en) begin
                        write_s = 1'b1;
                        if (hit_s) begin
                            trig_latch_s = 1'b1;
                            state_nxt_s  = (POST_LEN == 0) ? ST_DONE : ST_POST;
                        end else begin
                            state_nxt_s = ST_ARMED;
                        end
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end
                ST_POST: begin
                    if (sample_en) begin
                        write_s = 1'b1;
                        if (post_cnt_r == PTR_W'(1)) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_POST;
                        end
                    end else begin
                        state_nxt_s = ST_POST;
                    end
                end
                ST_DONE: begin
                    if (arm) begin
                        state_nxt_s = ST_ARMED;
                        clear_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Write pointer, fill count, trigger index and post-window counter.
    // Once the buffer is full every post-trigger write ages the trigger
    // entry by one, so trig_pos tracks it down to DEPTH-1-POST_LEN.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_r     <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W+1){1'b0}};
            trig_pos_r <= {PTR_W{1'b0}};
            post_cnt_r <= {PTR_W{1'b0}};
        end else if (abort_s) begin
            count_r <= {(PTR_W+1){1'b0}};
        end else if (clear_s) begin
            wptr_r     <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W+1){1'b0}};
            trig_pos_r <= {PTR_W{1'b0}};
        end else if (write_s) begin
            wptr_r <= wptr_r + PTR_W'(1);
            if (count_r != DEPTH_C) begin
                count_r <= count_r + (PTR_W+1)'(1);
            end
            if (trig_latch_s) begin
                trig_pos_r <= (count_r == DEPTH_C) ? LAST_IDX_C : count_r[PTR_W-1:0];
                post_cnt_r <= POST_LEN_C;
            end else if (state_r == ST_POST) begin
                post_cnt_r <= post_cnt_r - PTR_W'(1);
                if (count_r == DEPTH_C) begin
                    trig_pos_r <= trig_pos_r - PTR_W'(1);
                end
            end
        end
    end

    // Trace storage; no reset, contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (write_s) begin
            mem_r[wptr_r] <= cap_data_s;
        end
    end

    // Registered live view and trace readout (read-before-write on the RAM).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            check_data_r <= {DATA_W{1'b0}};
            rd_data_r    <= {DATA_W{1'b0}};
        end else begin
            check_data_r <= ch_sel(check_addr, ch_data);
            rd_data_r    <= rd_valid_s ? mem_r[rd_addr_s] : {DATA_W{1'b0}};
        end
    end

    assign state      = state_r;
    assign count      = count_r;
    assign trig_pos   = trig_pos_r;
    assign check_data = check_data_r;
    assign rd_data    = rd_data_r;

endmodule

// File: doc/debug_trace_probe.md
Name: debug_trace_probe

Overview:
- Parametrised successor to the single-cycle debug check mux.
- Selects one of NUM_CH probe channels for live viewing and records a chosen channel into a circular trace buffer.
- Recording is gated by a sample enable and stops after a masked value-match trigger plus a post-trigger window.
- Sits beside the CPU pipeline and feeds the PDU/debug readout path.

Parameters:
NUM_CH, 32, number of probe channels (1..32)
DATA_W, 32, width of each channel
ADDR_W, 5, channel-select width; NUM_CH <= 2**ADDR_W
DEPTH, 16, trace entries; power of two, >= 2
PTR_W, 4, log2(DEPTH)
POST_LEN, 4, samples captured after the trigger sample; 0 <= POST_LEN < DEPTH

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
ch_data  in  NUM_CH*DATA_W  channel i = ch_data[i*DATA_W +: DATA_W]
check_addr  in  ADDR_W  live-view channel select
check_data  out  DATA_W  registered live view
sample_en  in  1  one sample per high cycle (e.g. CPU step/commit)
cap_addr  in  ADDR_W  channel recorded into the trace
trig_addr  in  ADDR_W  channel compared for the trigger
trig_value  in  DATA_W  trigger compare value
trig_mask  in  DATA_W  compare bit mask; 1 = compare this bit
arm  in  1  pulse: start a capture
abort  in  1  pulse: return to IDLE
state  out  2  00 IDLE, 01 ARMED, 10 POST, 11 DONE
count  out  PTR_W+1  valid entries, saturating at DEPTH
trig_pos  out  PTR_W  read index of the trigger sample
rd_idx  in  PTR_W  read index; 0 = oldest entry
rd_data  out  DATA_W  registered trace read

Behaviour:
- Reset (rstn=0, async) values:
  - state=IDLE; check_data, rd_data, count, trig_pos, write pointer and post counter = 0.
  - Buffer contents are don't-care.
- Channel select: any address >= NUM_CH selects 0.
- check_data = ch[check_addr] registered, so it has 1-cycle latency.
- Trigger hit: (ch[trig_addr] & trig_mask) == (trig_value & trig_mask).
  - Evaluated only on a cycle where sample_en=1 and state=ARMED.
  - trig_mask=0 means the first sample triggers.
- The state machine advances only on rising clk edges.
- Priority: abort > arm > sampling.
- IDLE:
  - arm -> ARMED.
  - On arm: clear write pointer, count and trig_pos.
  - sample_en is ignored.
- ARMED:
  - On sample_en: write ch[cap_addr] at the write pointer, increment the pointer mod DEPTH, increment count (saturating at DEPTH).
  - Pre-trigger wrap-around overwrites the oldest entry.
  - If the same sample hits: that sample is stored first.
    - trig_pos is latched as that sample's read index (count after the write, minus 1, in oldest-relative terms).
    - If POST_LEN=0, go to DONE; otherwise go to POST with post counter = POST_LEN.
  - arm is ignored.
- POST:
  - Each sample_en writes as in ARMED and decrements the post counter.
  - After the write that brings the counter to 0, go to DONE.
  - No further trigger evaluation. arm is ignored.
- trig_pos is computed against the final buffer.
  - If a wrap after the trigger makes the trigger entry older, trig_pos = DEPTH-1-POST_LEN.
  - Otherwise trig_pos = index at trigger time.
  - Either way trig_pos always points at the stored trigger sample.
- DONE:
  - Buffer, count and trig_pos are frozen; sample_en is ignored.
  - arm -> ARMED with the same clears as from IDLE.
- abort (any state) -> IDLE and count=0.
  - Buffer RAM and trig_pos are not cleared.
  - abort and arm in the same cycle: abort wins.
- Readout, valid in every state:
  - oldest = (count < DEPTH) ? 0 : write pointer.
  - rd_data <= (rd_idx < count) ? buf[(oldest + rd_idx) mod DEPTH] : 0, with 1-cycle latency.
  - A read of the entry being written in the same cycle returns the old contents (read-before-write).
- Reset asserted mid-capture: immediate IDLE, all outputs return to their reset values.

Test Plan:
- Live view: ch[3]=0xDEAD_BEEF, check_addr=3 -> check_data=0xDEADBEEF one clk later; check_addr=31 with NUM_CH=25 -> 0.
- Basic capture: cap_addr=8 carrying 1,2,3,..., trig_value=5, mask=all-ones, sample_en every cycle, POST_LEN=4 -> DONE after the 9th sample; count=9, trig_pos=4, rd_idx 0..8 returns 1..9.
- Wrap: same setup but trig_value=20 -> count=16, oldest entry reads 9, trig_pos=11, rd_idx=15 returns 24.
- Gapped sampling: sample_en every 3rd cycle -> only gated samples are stored, same indices as the dense case.
- Immediate trigger: mask=0, POST_LEN=0 -> DONE after 1 sample; count=1, trig_pos=0; rd_idx=1 returns 0.
- Control edges:
  - arm+abort in the same cycle -> IDLE.
  - abort in POST -> IDLE, count=0.
  - arm in DONE -> ARMED with count=0.
  - rstn low mid-POST -> all outputs 0 without waiting for a clk edge.
